// File: rtl/i2c_temp_target.sv
// I2C target emulating the board temperature sensor register map (temp/config/T_low/T_high).
// SCL/SDA are oversampled on clk; SDA is driven open-drain through sda_oe.
module i2c_temp_target #(
   parameter logic [6:0]  DEV_ADDR  = 7'h48,
   parameter logic [15:0] CFG_RST   = 16'h60A0,
   parameter logic [15:0] TLOW_RST  = 16'h4B00,
   parameter logic [15:0] THIGH_RST = 16'h5000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [15:0] temp_data,
   output logic [15:0] cfg_reg,
   output logic [15:0] tlow_reg,
   output logic [15:0] thigh_reg,
   output logic        wr_strobe,
   output logic        busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
   } state_t;

   state_t      state_q;
   logic [2:0]  scl_sync_q, sda_sync_q;
   logic [3:0]  bit_cnt_q;
   logic [7:0]  shift_q, msb_q;
   logic [15:0] snap_q, cfg_q, tlow_q, thigh_q;
   logic [1:0]  ptr_q;
   logic        rw_q, byte_idx_q, ack_on_q;
   logic        sda_oe_q, busy_q, wr_strobe_q;

   // Stages [1:0] synchronise, stage [2] is the previous value for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync_q <= 3'b111;
         sda_sync_q <= 3'b111;
      end else begin
         scl_sync_q <= {scl_sync_q[1:0], scl_in};
         sda_sync_q <= {sda_sync_q[1:0], sda_in};
      end
   end

   logic        scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, last_bit;
   logic [7:0]  byte_d, rd_byte;
   logic        rd_bit;
   logic [15:0] ptr_val;

   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign scl_rise  =  scl_sync_q[1] & ~scl_sync_q[2];
   assign scl_fall  = ~scl_sync_q[1] &  scl_sync_q[2];
   assign start_det = scl_s & ~sda_sync_q[1] &  sda_sync_q[2];
   assign stop_det  = scl_s &  sda_sync_q[1] & ~sda_sync_q[2];
   assign last_bit  = (bit_cnt_q == 4'd7);
   assign byte_d    = {shift_q[6:0], sda_s};
   assign rd_byte   = byte_idx_q ? snap_q[7:0] : snap_q[15:8];
   // bit_cnt counts rising edges already completed, so the next bit out is 7-bit_cnt.
   assign rd_bit    = rd_byte[~bit_cnt_q[2:0]];

   always_comb begin
      ptr_val = temp_data;
      case (ptr_q)
         2'd1:    ptr_val = cfg_q;
         2'd2:    ptr_val = tlow_q;
         2'd3:    ptr_val = thigh_q;
         default: ptr_val = temp_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         msb_q       <= '0;
         snap_q      <= '0;
         ptr_q       <= '0;
         rw_q        <= 1'b0;
         byte_idx_q  <= 1'b0;
         ack_on_q    <= 1'b0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         cfg_q       <= CFG_RST;
         tlow_q      <= TLOW_RST;
         thigh_q     <= THIGH_RST;
      end else begin
         wr_strobe_q <= 1'b0;
         if (start_det) begin
            state_q   <= S_ADDR;
            bit_cnt_q <= '0;
            ack_on_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
         end else if (stop_det) begin
            state_q  <= S_IDLE;
            ack_on_q <= 1'b0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
         end else begin
            case (state_q)
               S_ADDR: if (scl_rise) begin
                  shift_q   <= byte_d;
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (last_bit) begin
                     bit_cnt_q <= '0;
                     if (byte_d[7:1] == DEV_ADDR) begin
                        state_q <= S_ADDR_ACK;
                        rw_q    <= byte_d[0];
                        busy_q  <= 1'b1;
                        // Snapshot once per read transfer; later bytes replay it.
                        if (byte_d[0]) begin
                           snap_q     <= ptr_val;
                           byte_idx_q <= 1'b0;
                        end
                     end else begin
                        state_q <= S_IGNORE;
                        busy_q  <= 1'b0;
                     end
                  end
               end
               S_PTR: if (scl_rise) begin
                  shift_q   <= byte_d;
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (last_bit) begin
                     bit_cnt_q  <= '0;
                     ptr_q      <= byte_d[1:0];
                     byte_idx_q <= 1'b0;
                     state_q    <= S_PTR_ACK;
                  end
               end
               S_WDATA: if (scl_rise) begin
                  shift_q   <= byte_d;
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (last_bit) begin
                     bit_cnt_q  <= '0;
                     state_q    <= S_WDATA_ACK;
                     byte_idx_q <= ~byte_idx_q;
                     if (!byte_idx_q) begin
                        msb_q <= byte_d;
                     end else if (ptr_q != 2'd0) begin
                        wr_strobe_q <= 1'b1;
                        case (ptr_q)
                           2'd1:    cfg_q   <= {msb_q, byte_d};
                           2'd2:    tlow_q  <= {msb_q, byte_d};
                           default: thigh_q <= {msb_q, byte_d};
                        endcase
                     end
                  end
               end
               // First fall after the 8th bit pulls SDA; the next fall ends the ACK clock.
               S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
                  if (!ack_on_q) begin
                     ack_on_q <= 1'b1;
                     sda_oe_q <= 1'b1;
                  end else begin
                     ack_on_q  <= 1'b0;
                     bit_cnt_q <= '0;
                     if (state_q == S_ADDR_ACK && rw_q) begin
                        state_q  <= S_RDATA;
                        sda_oe_q <= ~snap_q[15];
                     end else begin
                        state_q  <= (state_q == S_ADDR_ACK) ? S_PTR : S_WDATA;
                        sda_oe_q <= 1'b0;
                     end
                  end
               end
               S_RDATA: begin
                  if (scl_rise) begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt_q == 4'd8) begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= S_RACK;
                     end else begin
                        sda_oe_q <= ~rd_bit;
                     end
                  end
               end
               S_RACK: if (scl_rise) begin
                  if (!sda_s) begin
                     byte_idx_q <= ~byte_idx_q;
                     state_q    <= S_RDATA;
                  end else begin
                     state_q <= S_IGNORE;
                     busy_q  <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign sda_oe    = sda_oe_q;
   assign busy      = busy_q;
   assign wr_strobe = wr_strobe_q;
   assign cfg_reg   = cfg_q;
   assign tlow_reg  = tlow_q;
   assign thigh_reg = thigh_q;

endmodule

// File: doc/i2c_temp_target.md
# i2c_temp_target

I2C target (responder) that emulates the register map of the board temperature sensor, the 7-bit-addressed device our I2C controller configures and polls. It decodes START/STOP, address, pointer and data bytes on an oversampled SCL/SDA pair. It ACKs writes to the config and limit registers, and returns the temperature word on reads. It sits on the bench side of the bus so the controller's configure/read sequence can be exercised in simulation and on FPGA without a physical sensor.

## Interface
- DEV_ADDR, 7'h48, 7-bit target address matched against the first byte after START.
- CFG_RST, 16'h60A0, reset value of the config register (pointer 1).
- TLOW_RST, 16'h4B00, reset value of T_low (pointer 2).
- THIGH_RST, 16'h5000, reset value of T_high (pointer 3).

Ports:
- clk  in  1  system clock; must be at least 20x the SCL frequency.
- reset  in  1  synchronous, active-high; clock clk.
- scl_in  in  1  raw SCL from the pad; asynchronous.
- sda_in  in  1  raw SDA from the pad; asynchronous.
- sda_oe  out  1  1 = pull SDA low (open drain); 0 = release.
- temp_data  in  16  current temperature word served at pointer 0 (read-only).
- cfg_reg  out  16  config register.
- tlow_reg  out  16  T_low register.
- thigh_reg  out  16  T_high register.
- wr_strobe  out  1  one-cycle pulse when a 16-bit register write commits.
- busy  out  1  1 from an address-matched START until STOP or NACK.

## Operation
- Input synchronisation:
  - scl_in and sda_in each pass through a 2-flop synchroniser, then a third flop for edge detection.
  - Edges are taken only from the synchronised versions.
- Bus conditions:
  - START is SDA falling while SCL is high. STOP is SDA rising while SCL is high.
  - START in any state, including a repeated start, clears the bit counter and enters ADDR.
  - STOP in any state enters IDLE and releases sda_oe.
- States and transitions:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits MSB-first on SCL rising edges.
    - If bits [7:1] == DEV_ADDR, go to ADDR_ACK and latch rw = bit 0.
    - Otherwise go to IGNORE, which waits for START/STOP and never drives the bus.
  - ADDR_ACK: drives the ACK.
    - rw=0: go to PTR.
    - rw=1: snapshot the pointed register into shift_reg (temp_data when pointer=0), clear byte_idx, go to RDATA.
  - PTR: shifts 8 bits. Pointer is set to byte[1:0]; bits [7:2] are ignored. Go to PTR_ACK, clear byte_idx, then WDATA.
  - WDATA: shifts 8 bits, then WDATA_ACK.
    - byte_idx=0: hold the byte as the MSB.
    - byte_idx=1: commit {MSB, byte} to the pointed register and pulse wr_strobe.
    - Writes to pointer 0 are ACKed, discarded, and produce no wr_strobe.
    - byte_idx toggles, so a third byte starts a new MSB.
  - RDATA: shifts out shift_reg[15:8] (byte_idx=0) or shift_reg[7:0] (byte_idx=1), MSB first. Then RACK.
  - RACK: samples the controller's ACK on the 9th SCL rising edge.
    - ACK (SDA=0): toggle byte_idx and go to RDATA. After the LSB the same snapshot's MSB is repeated; there is no re-snapshot.
    - NACK: go to IGNORE.
- Reset values:
  - sda_oe=0, busy=0, wr_strobe=0.
  - cfg_reg=CFG_RST, tlow_reg=TLOW_RST, thigh_reg=THIGH_RST.
  - pointer=0, state=IDLE.
  - Reset mid-transfer releases SDA immediately; the registers return to their reset values.

## Timing
- sda_oe changes only in the clk cycle after a synchronised SCL falling edge is detected, i.e. 3–4 clk after the pad edge. It never changes while synchronised SCL is high, so the block never creates a false START/STOP.
- ACK phases: sda_oe=1 from the falling edge ending bit 8 until the falling edge ending bit 9.
- Read phases: each data bit is presented at the SCL falling edge that precedes it. The first bit is presented at the falling edge ending the ADDR_ACK/RACK clock, and sda_oe is released at the same edge for the master-ACK bit.
- wr_strobe fires in the cycle the LSB is sampled (8th SCL rising edge of the second data byte). The register updates in that same cycle.
- busy rises when the address matches (8th rising edge of ADDR) and falls on STOP, on NACK, or when IGNORE is entered.
- Simultaneous events: START/STOP detection takes priority over bit shifting in the same cycle.

## Test plan
- Config write:
  - Stimulus: START, 0x90, 0x01, 0x60, 0xA0, STOP.
  - Response: four ACKs, cfg_reg=16'h60A0, exactly one wr_strobe, busy low after STOP.
- Temperature read:
  - Stimulus: temp_data=16'h1910; START, 0x90, 0x00, repeated START, 0x91, read 2 bytes (ACK then NACK), STOP.
  - Response: bytes 0x19 then 0x10 on SDA; sda_oe released during the master-ACK bits.
- Snapshot stability: change temp_data to 16'hE700 between the MSB and the LSB of a read; the LSB read is still 0x10.
- Wrong address: START, 0xA0, 0x01, STOP. sda_oe stays 0 throughout, no register changes, busy stays 0.
- Read-only and extra bytes:
  - Write 0x00, 0x12, 0x34: all ACKed, no wr_strobe.
  - Then write pointer 3 followed by 0x50, 0x00, 0x4B, 0x00: two wr_strobes, final thigh_reg=16'h4B00.
- Reset mid-read: assert reset while driving MSB bit 3 low. sda_oe=0 next cycle, state=IDLE, cfg_reg=16'h60A0, and the next START/0x90 is ACKed normally.
